instr_fetch_unit: RTL

- Initiator side of the instruction-memory read interface for the single-cycle MIPS datapath.
- Owns the program counter and drives the word-aligned byte address to Instr_Memory.
- Takes back the combinational instruction word and forwards it to decode.
- Computes next-PC (sequential, branch, jump, jr), honours stall, and runs a small RUN/HALT/FAULT state machine with a retired-instruction counter.

---
 rtl/mips_fetch_pkg.sv | 34 +++
 rtl/instr_fetch_unit_if.sv | 17 +
 rtl/instr_fetch_unit_next_pc_sel.sv | 46 ++++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and helpers for the MIPS instruction fetch unit.
package mips_fetch_pkg;

    // Fetch control state: RUN fetches, HALT and FAULT are absorbing.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // Reason reported when the unit stops in FAULT.
    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_JR_ALIGN = 2'd1,
        FAULT_RANGE    = 2'd2
    } fault_code_e;

    // Opcode 6'b111111 with all other fields zero stops fetch.
    localparam logic [5:0]  HALT_OPCODE        = 6'b111111;
    localparam logic [31:0] HALT_INSTR_DEFAULT = {HALT_OPCODE, 26'd0};

    // J/JAL target: keep the top nibble of PC+4, splice in the word index.
    function automatic logic [31:0] jump_addr(input logic [31:0] pc_plus4,
                                              input logic [25:0] target);
        return {pc_plus4[31:28], target, 2'b00};
    endfunction

    // Branch target: PC+4 plus a word offset, wrapping at 32 bits.
    function automatic logic [31:0] branch_addr(input logic [31:0] pc_plus4,
                                                input logic [31:0] offset_words);
        return pc_plus4 + {offset_words[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: byte address out, combinational word back.
interface instr_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;

    // The fetch unit drives the address and consumes the returned word.
    modport master (
        output imem_addr,
        input  imem_instr
    );

    // The instruction memory answers the address with a word.
    modport slave (
        input  imem_addr,
        output imem_instr
    );
endinterface

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Next-PC priority mux: stall > jr > jump > branch > sequential.
// Purely combinational so it can be exercised on its own.
module next_pc_sel
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    input  logic        stall_i,
    input  logic        jr_i,
    input  logic [31:0] jr_addr_i,
    input  logic        jump_i,
    input  logic [25:0] jump_target_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_offset_i,
    output logic [31:0] next_pc_o,
    output logic        pc_update_o,
    output logic        jr_misalign_o
);

    // Pick the highest-priority source; a misaligned jr blocks the update.
    always_comb begin
        next_pc_o     = pc_i;
        pc_update_o   = 1'b0;
        jr_misalign_o = 1'b0;
        if (!stall_i) begin
            if (jr_i) begin
                if (jr_addr_i[1:0] != 2'b00) begin
                    jr_misalign_o = 1'b1;
                end else begin
                    next_pc_o   = jr_addr_i;
                    pc_update_o = 1'b1;
                end
            end else if (jump_i) begin
                next_pc_o   = jump_addr(pc_plus4_i, jump_target_i);
                pc_update_o = 1'b1;
            end else if (branch_taken_i) begin
                next_pc_o   = branch_addr(pc_plus4_i, branch_offset_i);
                pc_update_o = 1'b1;
            end else begin
                next_pc_o   = pc_plus4_i;
                pc_update_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, next-PC selection, RUN/HALT/FAULT
// control and a saturating retired-instruction counter.
module instr_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS  = 256,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         branch_offset,
    input  logic                jump,
    input  logic [25:0]         jump_target,
    input  logic                jr,
    input  logic [31:0]         jr_addr,
    instr_fetch_unit_if.master  imem,
    output logic [31:0]         instr,
    output logic [31:0]         pc_out,
    output logic [31:0]         pc_plus4,
    output logic                halted,
    output logic                fault,
    output logic [1:0]          fault_code,
    output logic [31:0]         fetch_count
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

    fetch_state_e state_q, state_d;
    fault_code_e  fault_code_q, fault_code_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_count_q, fetch_count_d;

    logic [31:0]  sel_next_pc;
    logic         sel_pc_update;
    logic         sel_jr_misalign;
    logic         pc_out_of_range;
    logic         is_halt_instr;

    assign pc_plus4        = pc_q + 32'd4;
    assign pc_out          = pc_q;
    assign imem.imem_addr  = pc_q;
    assign halted          = (state_q == ST_HALT);
    assign fault           = (state_q == ST_FAULT);
    assign fault_code      = fault_code_q;
    assign fetch_count     = fetch_count_q;
    assign pc_out_of_range = ({2'b00, pc_q[31:2]} >= MEM_LIMIT);
    assign is_halt_instr   = (imem.imem_instr == HALT_INSTR);

    // Decode only sees real instructions while running; otherwise a nop.
    always_comb begin
        instr = 32'h0000_0000;
        if (state_q == ST_RUN) begin
            instr = imem.imem_instr;
        end
    end

    next_pc_sel u_next_pc_sel (
        .pc_i            (pc_q),
        .pc_plus4_i      (pc_plus4),
        .stall_i         (stall),
        .jr_i            (jr),
        .jr_addr_i       (jr_addr),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .branch_taken_i  (branch_taken),
        .branch_offset_i (branch_offset),
        .next_pc_o       (sel_next_pc),
        .pc_update_o     (sel_pc_update),
        .jr_misalign_o   (sel_jr_misalign)
    );

    // Next state: halt beats range fault beats jr fault beats PC update.
    // The range check ignores stall so a stalled bad PC still faults.
    always_comb begin
        state_d       = state_q;
        fault_code_d  = fault_code_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            ST_RUN: begin
                if (!stall && is_halt_instr) begin
                    state_d = ST_HALT;
                end else if (pc_out_of_range) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_RANGE;
                end else if (sel_jr_misalign) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_JR_ALIGN;
                end else if (sel_pc_update) begin
                    pc_d = sel_next_pc;
                    if (fetch_count_q != 32'hFFFF_FFFF) begin
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
                end
            end
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // State, PC, fault reason and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            fault_code_q  <= FAULT_NONE;
            pc_q          <= RESET_PC;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            fault_code_q  <= fault_code_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule
